// File: rtl/avm_pattern_master.sv
// avm_pattern_master: Avalon-MM master that writes (index + DA) across a BASE/LEN window, optionally reading back each word to verify it.
module avm_pattern_master #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter logic [AW-1:0] BASE = '0,
  parameter int LEN = 256,
  parameter int GAP = 1
) (
  input  logic          csi_clk,
  input  logic          rsi_reset,
  output logic [AW-1:0] avm_m0_address,
  output logic          avm_m0_write,
  output logic [DW-1:0] avm_m0_writedata,
  output logic          avm_m0_read,
  input  logic [DW-1:0] avm_m0_readdata,
  input  logic          avm_m0_waitrequest,
  input  logic [DW-1:0] coe_c0_DA,
  input  logic          coe_c0_mode,
  input  logic          coe_c0_en,
  output logic          coe_c0_busy,
  output logic [15:0]   coe_c0_err_cnt,
  output logic [15:0]   coe_c0_pass_cnt
);
  typedef enum logic [2:0] {S_INIT, S_GAP, S_WR, S_RD, S_NEXT} state_t;
  localparam logic [AW-1:0] LAST = AW'(LEN - 1);
  localparam logic [3:0] GAP_LD = GAP > 0 ? 4'(GAP - 1) : 4'd0;
  state_t state, state_nx;
  logic [AW-1:0] cnt;
  logic [3:0] gap_cnt;
  logic [DW-1:0] da_q, exp_data;
  logic mode_q, xfer;
  assign exp_data = DW'(cnt) + da_q;
  assign xfer = !avm_m0_waitrequest;
  assign coe_c0_busy = state != S_INIT;
  always_comb begin
    state_nx = state;
    avm_m0_write = 1'b0;
    avm_m0_read = 1'b0;
    avm_m0_address = '1;
    avm_m0_writedata = '0;
    case (state)
      S_INIT: if (coe_c0_en) state_nx = GAP > 0 ? S_GAP : S_WR;
      S_GAP: if (gap_cnt == 4'd0) state_nx = S_WR;
      S_WR: begin
        avm_m0_write = 1'b1;
        avm_m0_address = BASE + cnt;
        avm_m0_writedata = exp_data;
        if (xfer) state_nx = mode_q ? S_RD : S_NEXT;
      end
      S_RD: begin
        avm_m0_read = 1'b1;
        avm_m0_address = BASE + cnt;
        if (xfer) state_nx = S_NEXT;
      end
      default: state_nx = S_INIT;
    endcase
  end
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state <= S_INIT;
      cnt <= '0;
      gap_cnt <= '0;
      da_q <= '0;
      mode_q <= 1'b0;
      coe_c0_err_cnt <= '0;
      coe_c0_pass_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT && coe_c0_en) begin
        da_q <= coe_c0_DA;
        mode_q <= coe_c0_mode;
        gap_cnt <= GAP_LD;
      end
      if (state == S_GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      if (state == S_RD && xfer && avm_m0_readdata != exp_data && coe_c0_err_cnt != 16'hFFFF)
        coe_c0_err_cnt <= coe_c0_err_cnt + 16'd1;
      if (state == S_NEXT) begin
        cnt <= cnt == LAST ? '0 : cnt + 1'b1;
        if (cnt == LAST) coe_c0_pass_cnt <= coe_c0_pass_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_avm_pattern_master.sv
// tb_avm_pattern_master: two masters (default window; LEN=4 at BASE=FE with no gap) checked by a transaction scoreboard.
module tb_avm_pattern_master;
  typedef struct {
    int g;
    bit rd;
    logic [7:0] a;
    logic [7:0] d;
    int dt;
  } txn_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic wr [2], rd [2], busy [2], en [2], mode [2];
  logic wait_r [2] = '{1'b0, 1'b0};
  logic [7:0] addr [2], wdata [2], rdata [2], da [2];
  logic [15:0] errc [2], passc [2];
  logic [7:0] mem [2][256];
  logic bad_en [2], rnd [2];
  logic [7:0] bad_addr [2];
  logic [7:0] stall_addr [2] = '{8'd0, 8'd0};
  int stall_until [2] = '{0, 0};
  int stalled [2] = '{0, 0};
  int cyc = 0, total = 0, bad = 0;
  int idx [2], passm [2], errm [2];
  txn_t q [$];
  txn_t mt;
  bit held [2] = '{1'b0, 1'b0};
  logic [17:0] snap [2];
  int last [2] = '{0, 0};
  int nst [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_slave
    assign rdata[g] = mem[g][addr[g]] ^ ((bad_en[g] && addr[g] == bad_addr[g]) ? 8'hFF : 8'h00);
  end

  avm_pattern_master u0 (
    .csi_clk(clk), .rsi_reset(rst),
    .avm_m0_address(addr[0]), .avm_m0_write(wr[0]), .avm_m0_writedata(wdata[0]),
    .avm_m0_read(rd[0]), .avm_m0_readdata(rdata[0]), .avm_m0_waitrequest(wait_r[0]),
    .coe_c0_DA(da[0]), .coe_c0_mode(mode[0]), .coe_c0_en(en[0]),
    .coe_c0_busy(busy[0]), .coe_c0_err_cnt(errc[0]), .coe_c0_pass_cnt(passc[0])
  );

  avm_pattern_master #(.BASE(8'hFE), .LEN(4), .GAP(0)) u1 (
    .csi_clk(clk), .rsi_reset(rst),
    .avm_m0_address(addr[1]), .avm_m0_write(wr[1]), .avm_m0_writedata(wdata[1]),
    .avm_m0_read(rd[1]), .avm_m0_readdata(rdata[1]), .avm_m0_waitrequest(wait_r[1]),
    .coe_c0_DA(da[1]), .coe_c0_mode(mode[1]), .coe_c0_en(en[1]),
    .coe_c0_busy(busy[1]), .coe_c0_err_cnt(errc[1]), .coe_c0_pass_cnt(passc[1])
  );

  function automatic int base_of(int g); return g == 1 ? 254 : 0; endfunction
  function automatic int len_of(int g);  return g == 1 ? 4 : 256;  endfunction
  function automatic int gap_of(int g);  return g == 1 ? 0 : 1;    endfunction

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: every word is a write of (index + DA) at BASE + index, plus a readback in verify mode.
  task automatic push_words(int g, int n, int d, bit m);
    txn_t t;
    for (int k = 0; k < n; k++) begin
      t.g = g;
      t.rd = 1'b0;
      t.a = 8'((base_of(g) + idx[g]) % 256);
      t.d = 8'((idx[g] + d) % 256);
      t.dt = k == 0 ? -1 : 3 + gap_of(g);
      q.push_back(t);
      if (m) begin
        t.rd = 1'b1;
        t.dt = 1;
        q.push_back(t);
        if (bad_en[g] && t.a == bad_addr[g] && errm[g] < 65535) errm[g]++;
      end
      idx[g]++;
      if (idx[g] == len_of(g)) begin
        idx[g] = 0;
        passm[g] = (passm[g] + 1) % 65536;
      end
    end
  endtask

  // Slave: waitrequest for the coming edge, from a targeted stall plan or random back-pressure.
  always begin
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      if ((wr[g] || rd[g]) && addr[g] == stall_addr[g] && stalled[g] < stall_until[g]) begin
        wait_r[g] = 1'b1;
        stalled[g]++;
      end else
        wait_r[g] = (wr[g] || rd[g]) && rnd[g] && $urandom_range(0, 2) == 0;
    end
  end

  // Monitor: pops the scoreboard on each accepted transfer; also checks stall stability and spacing.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr[g] || rd[g]) begin
        chk($sformatf("excl%0d", g), int'(wr[g] && rd[g]), 0);
        if (held[g]) chk($sformatf("stall_hold%0d", g), int'({wr[g], rd[g], addr[g], wdata[g]}), int'(snap[g]));
        if (wait_r[g]) begin
          held[g] = 1'b1;
          snap[g] = {wr[g], rd[g], addr[g], wdata[g]};
          nst[g]++;
        end else begin
          held[g] = 1'b0;
          chk($sformatf("expected_txn%0d", g), int'(q.size() > 0 && q[0].g == g), 1);
          if (q.size() > 0 && q[0].g == g) begin
            mt = q.pop_front();
            chk($sformatf("kind%0d", g), int'(rd[g]), int'(mt.rd));
            chk($sformatf("addr%0d", g), int'(addr[g]), int'(mt.a));
            if (!mt.rd) chk($sformatf("wdata%0d", g), int'(wdata[g]), int'(mt.d));
            if (mt.dt >= 0) chk($sformatf("period%0d", g), cyc - last[g] - nst[g], mt.dt);
          end
          if (wr[g]) mem[g][addr[g]] = wdata[g];
          last[g] = cyc;
          nst[g] = 0;
        end
      end else held[g] = 1'b0;
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 3000 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_idle(int g);
    for (int i = 0; i < 30 && busy[g]; i++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("idle%0d", g), int'(busy[g]), 0);
  endtask

  task automatic status(int g);
    chk($sformatf("err_cnt%0d", g), int'(errc[g]), errm[g]);
    chk($sformatf("pass_cnt%0d", g), int'(passc[g]), passm[g]);
  endtask

  task automatic run(int g, int n, int d, bit m);
    da[g] = 8'(d);
    mode[g] = m;
    push_words(g, n, d, m);
    en[g] = 1'b1;
    wait_empty();
    en[g] = 1'b0;
    wait_idle(g);
    status(g);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      en[g] = 1'b0; mode[g] = 1'b0; da[g] = 8'd0;
      bad_en[g] = 1'b0; bad_addr[g] = 8'd0; rnd[g] = 1'b0;
      idx[g] = 0; passm[g] = 0; errm[g] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_wr%0d", g), int'(wr[g]), 0);
      chk($sformatf("rst_rd%0d", g), int'(rd[g]), 0);
      chk($sformatf("rst_addr%0d", g), int'(addr[g]), 255);
      chk($sformatf("rst_wdata%0d", g), int'(wdata[g]), 0);
      chk($sformatf("rst_busy%0d", g), int'(busy[g]), 0);
      status(g);
    end
    rst = 1'b0;
    // Default master: DA=3 write-only, 3-cycle stall on the addr5 write.
    stall_addr[0] = 8'd5;
    stall_until[0] = stalled[0] + 3;
    run(0, 7, 3, 1'b0);
    // Verify mode with random back-pressure, then with one corrupted readback.
    rnd[0] = 1'b1;
    run(0, 4, int'($urandom_range(0, 255)), 1'b1);
    bad_en[0] = 1'b1;
    bad_addr[0] = 8'((base_of(0) + idx[0] + 2) % 256);
    run(0, 5, int'($urandom_range(0, 255)), 1'b1);
    bad_en[0] = 1'b0;
    rnd[0] = 1'b0;
    // Short wrapping window: FE, FF, 00, 01, then again.
    run(1, 4, int'($urandom_range(0, 255)), 1'b0);
    rnd[1] = 1'b1;
    run(1, 5, int'($urandom_range(0, 255)), 1'b0);
    run(1, 3, int'($urandom_range(0, 255)), 1'b1);
    rnd[1] = 1'b0;
    // Enable dropped while a write is in progress: only that word completes.
    stall_addr[1] = 8'((base_of(1) + idx[1]) % 256);
    stall_until[1] = stalled[1] + 2;
    da[1] = 8'($urandom_range(0, 255));
    mode[1] = 1'b0;
    push_words(1, 1, int'(da[1]), 1'b0);
    en[1] = 1'b1;
    for (int i = 0; i < 20 && !wr[1]; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wr_seen1", int'(wr[1]), 1);
    en[1] = 1'b0;
    wait_empty();
    wait_idle(1);
    repeat (10) @(posedge clk);
    #1;
    chk("no_strobe1", int'(wr[1] || rd[1]), 0);
    status(1);
    // Reset during a stalled write, then restart from BASE.
    stall_addr[0] = 8'((base_of(0) + idx[0]) % 256);
    stall_until[0] = stalled[0] + 1000;
    da[0] = 8'd5;
    mode[0] = 1'b0;
    push_words(0, 1, 5, 1'b0);
    en[0] = 1'b1;
    for (int i = 0; i < 30 && !(wr[0] && wait_r[0]); i++) @(negedge clk);
    chk("stalled_wr0", int'(wr[0] && wait_r[0]), 1);
    rst = 1'b1;
    en[0] = 1'b0;
    @(negedge clk);
    chk("rst_drop_wr0", int'(wr[0]), 0);
    chk("rst_drop_busy0", int'(busy[0]), 0);
    chk("rst_drop_addr0", int'(addr[0]), 255);
    stall_until[0] = stalled[0];
    q.delete();
    for (int g = 0; g < 2; g++) begin
      idx[g] = 0; passm[g] = 0; errm[g] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    status(0);
    status(1);
    run(0, 3, 3, 1'b0);
    run(1, 2, int'($urandom_range(0, 255)), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
